// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and request/response bundles used by the
// block-RAM responder and its response delay line.
package wb_pkg;

  localparam int WB_ADDR_BITS = 32;
  localparam int WB_DATA_BITS = 64;
  localparam int WB_SEL_BITS  = WB_DATA_BITS / 8;

  typedef struct packed {
    logic                    we;
    logic [WB_ADDR_BITS-1:0] addr;
    logic [WB_DATA_BITS-1:0] wdata;
    logic [WB_SEL_BITS-1:0]  sel;
  } wb_req_t;

  typedef struct packed {
    logic                    ack;
    logic                    err;
    logic [WB_DATA_BITS-1:0] rdata;
  } wb_rsp_t;

endpackage

// File: rtl/wb_resp_delay.sv
// Fixed-depth shift register of Wishbone responses with per-stage valids.
// A synchronous flush drops everything in flight on the next edge.
module wb_resp_delay
  import wb_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic    clock,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    in_valid,
  input  wb_rsp_t in_rsp,
  output logic    out_valid,
  output wb_rsp_t out_rsp
);

  if (STAGES == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_rsp   = in_rsp;
  end else begin : g_pipe
    logic [STAGES-1:0] valid_q, valid_d;
    wb_rsp_t           rsp_q [STAGES];
    wb_rsp_t           rsp_d [STAGES];

    always_comb begin
      valid_d = valid_q;
      rsp_d   = rsp_q;
      if (flush) begin
        valid_d = '0;
      end else begin
        valid_d[0] = in_valid;
        rsp_d[0]   = in_rsp;
        for (int i = 1; i < STAGES; i++) begin
          valid_d[i] = valid_q[i-1];
          rsp_d[i]   = rsp_q[i-1];
        end
      end
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int i = 0; i < STAGES; i++) rsp_q[i] <= '0;
      end else begin
        valid_q <= valid_d;
        for (int i = 0; i < STAGES; i++) rsp_q[i] <= rsp_d[i];
      end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_rsp   = rsp_q[STAGES-1];
  end

endmodule

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone responder backed by block RAM: fixed request-to-response
// latency, backpressure once MAX_OUTSTANDING requests are in flight.
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int ADDR_BITS       = WB_ADDR_BITS,
  parameter int DATA_BITS       = WB_DATA_BITS,
  parameter int SEL_BITS        = DATA_BITS / 8,
  parameter int MEM_WORDS       = 4096,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clock,
  input  logic                 RST_N,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [ADDR_BITS-1:0] wb_addr,
  input  logic [DATA_BITS-1:0] wb_wdata,
  input  logic [SEL_BITS-1:0]  wb_sel,
  output logic                 wb_stall,
  output logic                 wb_ack,
  output logic                 wb_err,
  output logic [DATA_BITS-1:0] wb_rdata
);

  localparam int IDX_BITS = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WB_ADDR_BITS-1:0] MEM_LIMIT = WB_ADDR_BITS'(MEM_WORDS);
  localparam logic [CNT_BITS-1:0]     MAX_CNT   = CNT_BITS'(MAX_OUTSTANDING);

  logic [WB_DATA_BITS-1:0] mem_q [MEM_WORDS];

  wb_req_t               req;
  logic                  in_range;
  logic [IDX_BITS-1:0]   idx;
  logic                  stall;
  logic                  accept;
  logic                  wr_en;
  logic                  emitted;
  wb_rsp_t               rsp_in;
  logic                  dly_valid;
  wb_rsp_t               dly_rsp;

  // ready_q holds stall high until the first edge after reset release.
  logic                    ready_q, ready_d;
  logic [CNT_BITS-1:0]     out_cnt_q, out_cnt_d;
  logic                    wb_ack_q, wb_ack_d;
  logic                    wb_err_q, wb_err_d;
  logic [WB_DATA_BITS-1:0] wb_rdata_q, wb_rdata_d;

  always_comb begin
    req.we    = wb_we;
    req.addr  = WB_ADDR_BITS'(wb_addr);
    req.wdata = WB_DATA_BITS'(wb_wdata);
    req.sel   = WB_SEL_BITS'(wb_sel);

    in_range = (req.addr < MEM_LIMIT);
    idx      = req.addr[IDX_BITS-1:0];
    stall    = !ready_q || (out_cnt_q == MAX_CNT);
    accept   = wb_cyc && wb_stb && !stall;
    wr_en    = accept && req.we && in_range;

    // Reads sample the array before this edge's write; only one request
    // is accepted per cycle so earlier writes are always visible.
    rsp_in     = '0;
    rsp_in.ack = in_range;
    rsp_in.err = !in_range;
    if (in_range && !req.we) rsp_in.rdata = mem_q[idx];
  end

  wb_resp_delay #(
    .STAGES (LATENCY - 1)
  ) u_delay (
    .clock     (clock),
    .rst_n     (RST_N),
    .flush     (!wb_cyc),
    .in_valid  (accept),
    .in_rsp    (rsp_in),
    .out_valid (dly_valid),
    .out_rsp   (dly_rsp)
  );

  always_comb begin
    ready_d    = 1'b1;
    emitted    = wb_ack_q || wb_err_q;
    wb_ack_d   = wb_cyc && dly_valid && dly_rsp.ack;
    wb_err_d   = wb_cyc && dly_valid && dly_rsp.err && !dly_rsp.ack;
    wb_rdata_d = wb_ack_d ? dly_rsp.rdata : '0;
    if (!wb_cyc) begin
      out_cnt_d = '0;
    end else begin
      out_cnt_d = out_cnt_q + CNT_BITS'(accept) - CNT_BITS'(emitted);
    end
  end

  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      ready_q    <= 1'b0;
      out_cnt_q  <= '0;
      wb_ack_q   <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_rdata_q <= '0;
    end else begin
      ready_q    <= ready_d;
      out_cnt_q  <= out_cnt_d;
      wb_ack_q   <= wb_ack_d;
      wb_err_q   <= wb_err_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < WB_SEL_BITS; i++) begin
        if (req.sel[i]) mem_q[idx][i*8 +: 8] <= req.wdata[i*8 +: 8];
      end
    end
  end

  assign wb_stall = stall;
  assign wb_ack   = wb_ack_q;
  assign wb_err   = wb_err_q;
  assign wb_rdata = DATA_BITS'(wb_rdata_q);

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: drivers issue requests with expected
// responses, a negedge monitor pops them from a scoreboard queue.
module tb_wb_mem_responder;

  localparam int LATENCY = 4;

  logic        clock;
  logic        RST_N;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [63:0] wb_wdata;
  logic [7:0]  wb_sel;
  logic        wb_stall;
  logic        wb_ack;
  logic        wb_err;
  logic [63:0] wb_rdata;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [63:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_resp  = 0;
  int   cyc_n   = 0;
  bit   mon_en  = 0;

  wb_mem_responder #(
    .MEM_WORDS       (4096),
    .LATENCY         (LATENCY),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clock    (clock),
    .RST_N    (RST_N),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_wdata (wb_wdata),
    .wb_sel   (wb_sel),
    .wb_stall (wb_stall),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err),
    .wb_rdata (wb_rdata)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    wb_stb = 1'b0;
    step(n);
  endtask

  // Holds the request until accepted, then records the expected response.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [7:0] sel, input logic e_ack, input logic [63:0] e_data);
    int   waited;
    exp_t e;
    waited   = 0;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_addr  = addr;
    wb_wdata = wdata;
    wb_sel   = sel;
    while (wb_stall && waited < 50) begin
      step(1);
      waited++;
    end
    if (waited >= 50) check("stall_timeout", 64'(waited), 64'd0);
    step(1);
    e.ack  = e_ack;
    e.err  = !e_ack;
    e.data = e_data;
    e.due  = 32'(cyc_n + LATENCY - 1);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    wb_stb = 1'b0;
    while (exp_q.size() != 0 && budget < 100) begin
      step(1);
      budget++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    step(2);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      check("ack_err_excl", 64'(wb_ack & wb_err), 64'd0);
      if (wb_ack || wb_err) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {62'd0, wb_ack, wb_err}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_ack", 64'(wb_ack), 64'(e.ack));
          check("rsp_err", 64'(wb_err), 64'(e.err));
          check("rsp_data", wb_rdata, e.data);
          check("rsp_cycle", 64'(cyc_n), 64'(e.due));
        end
      end else begin
        check("rdata_idle", wb_rdata, 64'd0);
      end
    end
  end

  logic [63:0] b2b_data [6];
  int          resp_base;

  initial begin
    b2b_data[0] = 64'hD0D0_0000_0000_0010;
    b2b_data[1] = 64'hD1D1_0000_0000_0011;
    b2b_data[2] = 64'hD2D2_0000_0000_0012;
    b2b_data[3] = 64'hD3D3_0000_0000_0013;
    b2b_data[4] = 64'hD4D4_0000_0000_0014;
    b2b_data[5] = 64'hD5D5_0000_0000_0015;

    RST_N    = 1'b0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_wdata = '0;
    wb_sel   = '0;
    step(3);
    check("rst_stall", 64'(wb_stall), 64'd1);
    check("rst_ack", 64'(wb_ack), 64'd0);
    check("rst_err", 64'(wb_err), 64'd0);
    check("rst_rdata", wb_rdata, 64'd0);
    RST_N  = 1'b1;
    wb_cyc = 1'b1;
    step(1);
    mon_en = 1'b1;

    // idle after release
    for (int i = 0; i < 20; i++) begin
      check("idle_stall", 64'(wb_stall), 64'd0);
      check("idle_ack", 64'(wb_ack), 64'd0);
      check("idle_err", 64'(wb_err), 64'd0);
      step(1);
    end

    // full write then read
    issue(1'b1, 32'd5, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 64'd0);
    issue(1'b0, 32'd5, 64'd0, 8'h00, 1'b1, 64'h1122_3344_5566_7788);
    drain();

    // partial byte write, then a zero-select write that must change nothing
    issue(1'b1, 32'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b1, 64'd0);
    issue(1'b0, 32'd5, 64'd0, 8'h00, 1'b1, 64'h1122_3344_AAAA_AAAA);
    issue(1'b1, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 64'd0);
    issue(1'b0, 32'd5, 64'd0, 8'h00, 1'b1, 64'h1122_3344_AAAA_AAAA);
    drain();

    // back-to-back reads hitting the outstanding limit
    for (int i = 0; i < 6; i++) issue(1'b1, 32'(16 + i), b2b_data[i], 8'hFF, 1'b1, 64'd0);
    drain();
    resp_base = n_resp;
    for (int i = 0; i < 4; i++) issue(1'b0, 32'(16 + i), 64'd0, 8'h00, 1'b1, b2b_data[i]);
    check("b2b_stall_rise", 64'(wb_stall), 64'd1);
    check("b2b_first_ack", 64'(wb_ack), 64'd1);
    idle(1);
    check("b2b_stall_fall", 64'(wb_stall), 64'd0);
    for (int i = 4; i < 6; i++) issue(1'b0, 32'(16 + i), 64'd0, 8'h00, 1'b1, b2b_data[i]);
    drain();
    check("b2b_count", 64'(n_resp - resp_base), 64'd6);

    // range boundary: last word ok, first out-of-range word and high bits error
    issue(1'b1, 32'd4095, 64'h0BAD_F00D_CAFE_4095, 8'hFF, 1'b1, 64'd0);
    issue(1'b0, 32'd4095, 64'd0, 8'h00, 1'b1, 64'h0BAD_F00D_CAFE_4095);
    issue(1'b0, 32'd4096, 64'd0, 8'h00, 1'b0, 64'd0);
    issue(1'b1, 32'h0001_0005, 64'h5555_5555_5555_5555, 8'hFF, 1'b0, 64'd0);
    issue(1'b0, 32'd5, 64'd0, 8'h00, 1'b1, 64'h1122_3344_AAAA_AAAA);
    drain();

    // cancellation by dropping wb_cyc
    issue(1'b1, 32'd20, 64'h2020_2020_2020_2020, 8'hFF, 1'b1, 64'd0);
    issue(1'b1, 32'd21, 64'h2121_2121_2121_2121, 8'hFF, 1'b1, 64'd0);
    issue(1'b1, 32'd22, 64'h2222_2222_2222_2222, 8'hFF, 1'b1, 64'd0);
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
    step(1);
    exp_q.delete();
    wb_cyc = 1'b1;
    check("cancel_stall", 64'(wb_stall), 64'd0);
    check("cancel_outstanding", 64'(dut.out_cnt_q), 64'd0);
    idle(10);
    issue(1'b0, 32'd20, 64'd0, 8'h00, 1'b1, 64'h2020_2020_2020_2020);
    issue(1'b0, 32'd21, 64'd0, 8'h00, 1'b1, 64'h2121_2121_2121_2121);
    issue(1'b0, 32'd22, 64'd0, 8'h00, 1'b1, 64'h2222_2222_2222_2222);
    drain();

    // reset mid-burst with two reads pending
    issue(1'b1, 32'd30, 64'h3030_3030_1234_5678, 8'hFF, 1'b1, 64'd0);
    drain();
    issue(1'b0, 32'd30, 64'd0, 8'h00, 1'b1, 64'h3030_3030_1234_5678);
    issue(1'b0, 32'd31, 64'd0, 8'h00, 1'b1, 64'd0);
    wb_stb = 1'b0;
    RST_N  = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_stall", 64'(wb_stall), 64'd1);
    check("midrst_ack", 64'(wb_ack), 64'd0);
    step(2);
    RST_N = 1'b1;
    step(1);
    check("postrst_stall", 64'(wb_stall), 64'd0);
    idle(10);
    issue(1'b0, 32'd30, 64'd0, 8'h00, 1'b1, 64'h3030_3030_1234_5678);
    issue(1'b0, 32'd5, 64'd0, 8'h00, 1'b1, 64'h1122_3344_AAAA_AAAA);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
